// File: rtl/ga_chrom_queue.sv
// ============================================================================
// Module   : ga_chrom_queue
// Purpose  : Chromosome FIFO between the GA population generators and the
//            fitness-evaluation stage. One full chromosome can be pushed per
//            cycle. The oldest entry is presented show-ahead on the head
//            output, and the consumer removes it with a single-cycle pop.
//            Sticky flags record refused pushes and pops on an empty queue.
//            sw_rst flushes the queue between GA runs.
//
// Ports    : clk              - clock, all state updates on posedge
//            rstn             - asynchronous active-low reset
//            sw_rst           - synchronous flush, active-high, has priority
//                               over push and pop
//            queue_push       - write strobe, one chromosome per cycle
//            queue_chromosome - write data, sampled together with queue_push
//            queue_pop        - consumer removes the head entry
//            head_chromosome  - oldest entry, or 0 when the queue is empty
//            queue_empty      - no entries stored
//            queue_full       - DEPTH entries stored
//            queue_count      - current occupancy
//            overflow_err     - sticky, set when a push was refused
//            underflow_err    - sticky, set when a pop hit an empty queue
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ga_chrom_queue #(
    parameter int DATA_W      = 6,
    parameter int M_MAX       = 32,
    parameter int CHROM_MAX_W = DATA_W * M_MAX,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sw_rst,
    input  logic                   queue_push,
    input  logic [CHROM_MAX_W-1:0] queue_chromosome,
    input  logic                   queue_pop,
    output logic [CHROM_MAX_W-1:0] head_chromosome,
    output logic                   queue_empty,
    output logic                   queue_full,
    output logic [CNT_W-1:0]       queue_count,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH just by
    // overflowing their own width.
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_DEPTH   = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CHROM_MAX_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic                   r_underflow;

    // ------------------------------------------------------------------------
    // Status decodes. These come only from the registered count, so there is
    // no combinational path from push/pop to any output.
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // ------------------------------------------------------------------------
    // Accept rules, evaluated on the pre-edge state. A push into a full queue
    // is accepted only when a valid pop frees a slot in the same cycle. A pop
    // on an empty queue is never valid, even when a push arrives with it.
    // ------------------------------------------------------------------------
    logic w_pop_ok;
    logic w_push_ok;
    logic w_push_refused;
    logic w_pop_refused;

    assign w_pop_ok       = queue_pop & ~w_empty;
    assign w_push_ok      = queue_push & (~w_full | w_pop_ok);
    assign w_push_refused = queue_push & ~w_push_ok;
    assign w_pop_refused  = queue_pop & w_empty;

    // The occupancy moves by +1, -1 or 0. Push and pop together cancel out.
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Pointer, count and error-flag registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (sw_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            if (w_push_refused) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_refused) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage array. It has no reset, so it stays a plain register file.
    // When the queue is empty the head output is forced to 0, so stale
    // contents are never visible after a reset or a flush. A push in the
    // same cycle as sw_rst is discarded. When the queue is full, a
    // simultaneous push and pop writes into the slot at wr_ptr, which equals
    // rd_ptr and is the slot the pop just freed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok && !sw_rst) begin
            r_mem[r_wr_ptr] <= queue_chromosome;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign head_chromosome = w_empty ? '0 : r_mem[r_rd_ptr];
    assign queue_empty     = w_empty;
    assign queue_full      = w_full;
    assign queue_count     = r_count;
    assign overflow_err    = r_overflow;
    assign underflow_err   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_ga_chrom_queue.sv
// ============================================================================
// Module   : tb_ga_chrom_queue
// Purpose  : Self-checking directed testbench for ga_chrom_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ga_chrom_queue;

    localparam int c_DATA_W = 6;
    localparam int c_M_MAX  = 32;
    localparam int c_CW     = c_DATA_W * c_M_MAX;
    localparam int c_DEPTH  = 16;
    localparam int c_CNT_W  = $clog2(c_DEPTH + 1);

    logic                 clk;
    logic                 rstn;
    logic                 sw_rst;
    logic                 queue_push;
    logic [c_CW-1:0]      queue_chromosome;
    logic                 queue_pop;
    logic [c_CW-1:0]      head_chromosome;
    logic                 queue_empty;
    logic                 queue_full;
    logic [c_CNT_W-1:0]   queue_count;
    logic                 overflow_err;
    logic                 underflow_err;

    int n_checks;
    int n_errors;

    ga_chrom_queue #(
        .DATA_W      (c_DATA_W),
        .M_MAX       (c_M_MAX),
        .CHROM_MAX_W (c_CW),
        .DEPTH       (c_DEPTH),
        .CNT_W       (c_CNT_W)
    ) u_dut (
        .clk              (clk),
        .rstn             (rstn),
        .sw_rst           (sw_rst),
        .queue_push       (queue_push),
        .queue_chromosome (queue_chromosome),
        .queue_pop        (queue_pop),
        .head_chromosome  (head_chromosome),
        .queue_empty      (queue_empty),
        .queue_full       (queue_full),
        .queue_count      (queue_count),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_CW-1:0] obs,
                         input logic [c_CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus. Inputs change 1 time unit after a rising
    // edge and are sampled at the next edge. The task returns 1 time unit
    // after that edge, with the inputs idle again.
    task automatic cyc(input logic push, input logic [c_CW-1:0] d,
                       input logic pop);
        queue_push       = push;
        queue_chromosome = d;
        queue_pop        = pop;
        @(posedge clk);
        #1;
        queue_push       = 1'b0;
        queue_chromosome = '0;
        queue_pop        = 1'b0;
        sw_rst           = 1'b0;
    endtask

    initial begin
        logic [c_CW-1:0] exp_v;
        int              exp_cnt;

        n_checks         = 0;
        n_errors         = 0;
        rstn             = 1'b0;
        sw_rst           = 1'b0;
        queue_push       = 1'b0;
        queue_pop        = 1'b0;
        queue_chromosome = '0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", queue_empty, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_empty_after", queue_empty, 1);
        check("rst_full", queue_full, 0);
        check("rst_count", queue_count, 0);
        check("rst_head", head_chromosome, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_udf", underflow_err, 0);

        // ---------------- fill / drain ----------------
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, c_CW'(i), 1'b0);
            check("fill_count", queue_count, i);
            check("fill_head", head_chromosome, 1);
        end
        check("fill_full", queue_full, 1);
        check("fill_empty", queue_empty, 0);
        for (int i = 1; i <= 16; i++) begin
            check("drain_head", head_chromosome, i);
            cyc(1'b0, '0, 1'b1);
            check("drain_count", queue_count, 16 - i);
        end
        check("drain_empty", queue_empty, 1);
        check("drain_head0", head_chromosome, 0);
        check("drain_ovf", overflow_err, 0);
        check("drain_udf", underflow_err, 0);

        // ---------------- overflow ----------------
        for (int i = 1; i <= 16; i++) cyc(1'b1, c_CW'(i), 1'b0);
        cyc(1'b1, c_CW'(8'hAA), 1'b0);
        check("ovf_flag", overflow_err, 1);
        check("ovf_count", queue_count, 16);
        check("ovf_head", head_chromosome, 1);
        cyc(1'b1, c_CW'(8'hBB), 1'b1);
        check("fullpp_count", queue_count, 16);
        check("fullpp_head", head_chromosome, 2);
        check("fullpp_full", queue_full, 1);
        for (int k = 0; k < 16; k++) begin
            exp_v = (k == 15) ? c_CW'(8'hBB) : c_CW'(k + 2);
            check("ovf_drain_head", head_chromosome, exp_v);
            cyc(1'b0, '0, 1'b1);
        end
        check("ovf_drain_empty", queue_empty, 1);
        check("ovf_udf_clear", underflow_err, 0);

        // ---------------- underflow / push+pop on empty ----------------
        cyc(1'b0, '0, 1'b1);
        check("udf_flag", underflow_err, 1);
        check("udf_count", queue_count, 0);
        cyc(1'b1, c_CW'(5), 1'b1);
        check("emptypp_count", queue_count, 1);
        check("emptypp_head", head_chromosome, 5);
        check("udf_sticky", underflow_err, 1);
        check("ovf_sticky", overflow_err, 1);
        cyc(1'b0, '0, 1'b1);
        check("emptypp_drain", queue_empty, 1);

        // Flush to clear the sticky flags before the wrap test.
        sw_rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("flush_ovf", overflow_err, 0);
        check("flush_udf", underflow_err, 0);

        // ---------------- wrap-around ----------------
        exp_v = c_CW'(100);
        for (int c = 0; c < 40; c++) begin
            if (c >= 3) check("wrap_head", head_chromosome, exp_v);
            cyc(1'b1, c_CW'(100 + c), (c >= 3));
            if (c >= 3) exp_v = exp_v + 1'b1;
            exp_cnt = (c < 3) ? c + 1 : 3;
            check("wrap_count", queue_count, exp_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            check("wrap_tail_head", head_chromosome, exp_v);
            cyc(1'b0, '0, 1'b1);
            exp_v = exp_v + 1'b1;
        end
        check("wrap_empty", queue_empty, 1);
        check("wrap_ovf", overflow_err, 0);
        check("wrap_udf", underflow_err, 0);

        // ---------------- sw_rst ----------------
        cyc(1'b0, '0, 1'b1);
        for (int i = 1; i <= 17; i++) cyc(1'b1, c_CW'(i + 50), 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1);
        check("pre_swrst_count", queue_count, 7);
        check("pre_swrst_ovf", overflow_err, 1);
        check("pre_swrst_udf", underflow_err, 1);
        check("pre_swrst_head", head_chromosome, 60);
        sw_rst = 1'b1;
        cyc(1'b1, c_CW'(8'h77), 1'b0);
        check("swrst_count", queue_count, 0);
        check("swrst_empty", queue_empty, 1);
        check("swrst_head", head_chromosome, 0);
        check("swrst_ovf", overflow_err, 0);
        check("swrst_udf", underflow_err, 0);
        cyc(1'b1, c_CW'(9), 1'b0);
        check("post_swrst_head", head_chromosome, 9);
        check("post_swrst_count", queue_count, 1);

        // ---------------- async rstn mid-operation ----------------
        #2;
        rstn = 1'b0;
        #1;
        check("arst_count", queue_count, 0);
        check("arst_empty", queue_empty, 1);
        check("arst_head", head_chromosome, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("arst_release_empty", queue_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
